dsp_scroll_arb: RTL and testbench

Sits between the CPU bus and the character display memory port (12-bit word address = row[13:9], col[8:2]; 16-bit data; reads stall one cycle via wait, writes complete in one cycle).
- Arbitrates the display port between the CPU and an internal hardware engine.
- The engine performs whole-screen clear and one-line scroll-up with fill, so software need not loop over ROWS*COLS words.
- The CPU has per-transaction priority; the engine uses idle bus cycles.

---
 rtl/dsp_pkg.sv | 35 +++
 rtl/dsp_scroll_arb_if.sv | 26 ++
 rtl/dsp_bus_arb.sv | 103 ++++++++++
 rtl/dsp_scroll_arb.sv | 184 ++++++++++++++++++
 tb/tb_dsp_scroll_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
// Shared types and field widths for the character display port slice.
// A display word address is {row[4:0], col[6:0]} (CPU byte address [13:2]);
// display data words are 16 bits wide.
// ----------------------------------------------------------------------------
package dsp_pkg;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DATA_W = 16;

  // Clear/scroll engine states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COPY_RD = 2'd1,
    COPY_WR = 2'd2,
    FILL_WR = 2'd3
  } eng_state_e;

  // Display port owner for the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_ENG  = 2'd2
  } gnt_e;

  // Pack a (row, col) screen position into a display word address
  function automatic logic [ADDR_W-1:0] scr_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/dsp_scroll_arb_if.sv
// ----------------------------------------------------------------------------
// dsp_scroll_arb_if
// Display-port style bus: a master issues en/wr/addr/wr_data, the slave
// answers with wt (stall) and rd_data. Used both for the CPU side (this block
// is the slave) and the display memory side (this block is the master).
//   addr    : word address {row, col}
//   en      : access request
//   wr      : 1 = write, 0 = read
//   wt      : wait; a read stalls one cycle, a write completes at once
//   wr_data : write data
//   rd_data : read data, valid when en & ~wr & ~wt
// ----------------------------------------------------------------------------
interface dsp_scroll_arb_if;
  import dsp_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              wr;
  logic              wt;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output addr, en, wr, wr_data, input wt, rd_data);
  modport slave  (input addr, en, wr, wr_data, output wt, rd_data);

endinterface

// File: rtl/dsp_bus_arb.sv
// ----------------------------------------------------------------------------
// dsp_bus_arb
// Two-master arbiter for the display port: the CPU wins any cycle it asks,
// the internal engine gets idle cycles. A read that has started (wt seen) is
// locked to its owner through its completion cycle so it is never preempted.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   cpu (slave)     : CPU request bus; wt stalls the CPU
//   dsp (master)    : display memory port
//   eng_req/eng_wr/eng_addr/eng_wr_data : engine request
//   eng_ack         : engine access completes this cycle
//   eng_rd_data     : engine read data (valid with eng_ack on a read)
// ----------------------------------------------------------------------------
module dsp_bus_arb
  import dsp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  dsp_scroll_arb_if.slave   cpu,
  dsp_scroll_arb_if.master  dsp,
  input  logic              eng_req,
  input  logic              eng_wr,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  output logic              eng_ack,
  output logic [DATA_W-1:0] eng_rd_data
);

  gnt_e              gnt_s;
  gnt_e              gnt_held_q, gnt_held_d;
  logic              lock_q, lock_d;
  logic [ADDR_W-1:0] addr_s;
  logic              en_s;
  logic              wr_s;
  logic [DATA_W-1:0] wr_data_s;

  // Grant: a locked read keeps its owner, otherwise CPU first, then engine
  always_comb begin
    if (lock_q) begin
      gnt_s = gnt_held_q;
    end else if (cpu.en) begin
      gnt_s = GNT_CPU;
    end else if (eng_req) begin
      gnt_s = GNT_ENG;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Route the granted requester onto the display port
  always_comb begin
    addr_s    = '0;
    en_s      = 1'b0;
    wr_s      = 1'b0;
    wr_data_s = '0;
    case (gnt_s)
      GNT_CPU: begin
        addr_s    = cpu.addr;
        en_s      = cpu.en;
        wr_s      = cpu.wr;
        wr_data_s = cpu.wr_data;
      end
      GNT_ENG: begin
        addr_s    = eng_addr;
        en_s      = 1'b1;
        wr_s      = eng_wr;
        wr_data_s = eng_wr_data;
      end
      default: begin
        en_s = 1'b0;
      end
    endcase
  end

  // A read still stalled by the port holds the grant into its completion cycle
  always_comb begin
    lock_d     = en_s & ~wr_s & dsp.wt;
    gnt_held_d = gnt_s;
  end

  // Lock and held-grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      gnt_held_q <= GNT_NONE;
    end else begin
      lock_q     <= lock_d;
      gnt_held_q <= gnt_held_d;
    end
  end

  assign dsp.addr    = addr_s;
  assign dsp.en      = en_s;
  assign dsp.wr      = wr_s;
  assign dsp.wr_data = wr_data_s;

  assign cpu.rd_data = dsp.rd_data;
  assign cpu.wt      = cpu.en & ((gnt_s != GNT_CPU) | dsp.wt);

  assign eng_ack     = (gnt_s == GNT_ENG) & ~dsp.wt;
  assign eng_rd_data = dsp.rd_data;

endmodule

// File: rtl/dsp_scroll_arb.sv
// ----------------------------------------------------------------------------
// dsp_scroll_arb
// Display port front end: shares the character memory between the CPU and a
// hardware engine that clears the whole screen or scrolls it up one row and
// fills the last row, using only cycles the CPU leaves idle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cpu (slave)         : CPU bus (addr/en/wr/wr_data in, wt/rd_data out)
//   dsp (master)        : display memory port
//   cmd_clear           : pulse, fill the whole screen with fill_data
//   cmd_scroll          : pulse, scroll up one row and fill the last row
//   fill_data           : fill word, latched when a command is accepted
//   busy                : engine operation in progress
//   done                : one-cycle pulse after the last engine write
// ----------------------------------------------------------------------------
module dsp_scroll_arb
  import dsp_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 80
) (
  input  logic              clk,
  input  logic              reset,
  dsp_scroll_arb_if.slave   cpu,
  dsp_scroll_arb_if.master  dsp,
  input  logic              cmd_clear,
  input  logic              cmd_scroll,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] LAST_COPY_ROW = ROW_W'(ROWS - 2);
  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(COLS - 1);

  eng_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              busy_q;
  logic              done_q;

  logic              eng_req_s;
  logic              eng_wr_s;
  logic [ADDR_W-1:0] eng_addr_s;
  logic [DATA_W-1:0] eng_wr_data_s;
  logic              eng_ack_s;
  logic [DATA_W-1:0] eng_rd_data_s;

  dsp_bus_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .cpu         (cpu),
    .dsp         (dsp),
    .eng_req     (eng_req_s),
    .eng_wr      (eng_wr_s),
    .eng_addr    (eng_addr_s),
    .eng_wr_data (eng_wr_data_s),
    .eng_ack     (eng_ack_s),
    .eng_rd_data (eng_rd_data_s)
  );

  // Engine bus request: copy reads come from the row below the one written
  always_comb begin
    eng_req_s = (state_q != IDLE);
    eng_wr_s  = (state_q != COPY_RD);
    if (state_q == COPY_RD) begin
      eng_addr_s = scr_addr(row_q + ROW_W'(1), col_q);
    end else begin
      eng_addr_s = scr_addr(row_q, col_q);
    end
    if (state_q == COPY_WR) begin
      eng_wr_data_s = hold_q;
    end else begin
      eng_wr_data_s = fill_q;
    end
  end

  // Engine next state; counters move only when the engine access completes
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (cmd_clear) begin
          fill_d  = fill_data;
          row_d   = '0;
          col_d   = '0;
          state_d = FILL_WR;
        end else if (cmd_scroll) begin
          fill_d = fill_data;
          row_d  = '0;
          col_d  = '0;
          // a single-row screen has nothing to copy
          if (ROWS == 1) begin
            state_d = FILL_WR;
          end else begin
            state_d = COPY_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COPY_RD: begin
        if (eng_ack_s) begin
          hold_d  = eng_rd_data_s;
          state_d = COPY_WR;
        end else begin
          state_d = COPY_RD;
        end
      end
      COPY_WR: begin
        if (eng_ack_s) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_COPY_ROW) begin
              row_d   = LAST_ROW;
              state_d = FILL_WR;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = COPY_RD;
            end
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = COPY_RD;
          end
        end else begin
          state_d = COPY_WR;
        end
      end
      FILL_WR: begin
        if (eng_ack_s) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = IDLE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = FILL_WR;
            end
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = FILL_WR;
          end
        end else begin
          state_d = FILL_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Engine state, counters and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dsp_scroll_arb.sv
// ----------------------------------------------------------------------------
// tb_dsp_scroll_arb
// Scoreboard bench for dsp_scroll_arb at ROWS=3, COLS=4 with a behavioural
// display memory (reads stall one cycle). Stimulus pushes expected CPU read
// data and expected busy lengths; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_dsp_scroll_arb;
  import dsp_pkg::*;

  localparam int ROWS = 3;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_clear = 1'b0;
  logic        cmd_scroll = 1'b0;
  logic [15:0] fill_data = 16'h0000;
  logic        busy;
  logic        done;

  dsp_scroll_arb_if cpu_if ();
  dsp_scroll_arb_if dsp_if ();

  dsp_scroll_arb #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (cpu_if),
    .dsp        (dsp_if),
    .cmd_clear  (cmd_clear),
    .cmd_scroll (cmd_scroll),
    .fill_data  (fill_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Display memory model: write in one cycle, read stalls one cycle
  logic [15:0] mem [0:4095];
  logic        rd_ph_q = 1'b0;
  assign dsp_if.wt = dsp_if.en & ~dsp_if.wr & ~rd_ph_q;
  always @(posedge clk) begin
    if (dsp_if.en && dsp_if.wr) mem[dsp_if.addr] <= dsp_if.wr_data;
    rd_ph_q        <= dsp_if.wt;
    dsp_if.rd_data <= mem[dsp_if.addr];
  end

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        rd_q[$];
  logic [15:0] done_q[$];
  exp_t        mon_e;
  exp_t        push_e;
  int          n_checks = 0;
  int          n_errs = 0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] ad(input int r, input int c);
    return {5'(r), 7'(c)};
  endfunction

  function automatic logic [15:0] wd(input int r, input int c);
    return {4'h0, ad(r, c)};
  endfunction

  // Monitor: CPU read data and busy length at each done pulse
  always @(negedge clk) begin
    if (cpu_if.en && !cpu_if.wr && !cpu_if.wt) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL rd_unexpected: got %h expected no read", cpu_if.rd_data);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.name, cpu_if.rd_data, mon_e.val);
      end
    end
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL done_unexpected: got done=1 expected none (busy_cnt %0d)", busy_cnt);
        end else begin
          check("busy_cycles", 16'(busy_cnt), done_q.pop_front());
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [11:0] addr, input logic [15:0] data);
    int n;
    cpu_if.addr = addr; cpu_if.wr = 1'b1; cpu_if.wr_data = data; cpu_if.en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_if.wt && n < 50);
    if (cpu_if.wt) check("wr_timeout", 16'(cpu_if.wt), 16'h0000);
    tick();
    cpu_if.en = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] addr, input logic [15:0] exp, input string name);
    int n;
    push_e.name = name; push_e.val = exp;
    rd_q.push_back(push_e);
    cpu_if.addr = addr; cpu_if.wr = 1'b0; cpu_if.en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_if.wt && n < 50);
    if (cpu_if.wt) check("rd_timeout", 16'(cpu_if.wt), 16'h0000);
    tick();
    cpu_if.en = 1'b0;
  endtask

  task automatic preload();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cpu_write(ad(r, c), wd(r, c));
  endtask

  task automatic issue(input logic clr, input logic scr, input logic [15:0] fill);
    cmd_clear = clr; cmd_scroll = scr; fill_data = fill;
    tick();
    cmd_clear = 1'b0; cmd_scroll = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 400);
    if (!done) check("done_timeout", 16'(done), 16'h0001);
    tick();
  endtask

  task automatic read_all(input logic [15:0] fill, input string name);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cpu_read(ad(r, c), fill, name);
  endtask

  task automatic read_scroll(input logic [15:0] fill, input string name);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cpu_read(ad(r, c), (r < ROWS - 1) ? wd(r + 1, c) : fill, name);
  endtask

  initial begin
    cpu_if.en = 1'b0; cpu_if.wr = 1'b0; cpu_if.addr = 12'h000; cpu_if.wr_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    check("rst_dsp_en", 16'(dsp_if.en), 16'h0000);
    check("rst_cpu_wt", 16'(cpu_if.wt), 16'h0000);
    tick();

    // Uncontended clear
    preload();
    done_q.push_back(16'd12);
    issue(1'b1, 1'b0, 16'h0720);
    wait_done();
    read_all(16'h0720, "clear_word");

    // Uncontended scroll
    preload();
    done_q.push_back(16'd28);
    issue(1'b0, 1'b1, 16'h0000);
    wait_done();
    read_scroll(16'h0000, "scroll_word");

    // Scroll with a CPU read arriving in the engine's read-completion cycle
    preload();
    done_q.push_back(16'd30);
    issue(1'b0, 1'b1, 16'h0000);
    repeat (7) tick();
    push_e.name = "contend_rd"; push_e.val = wd(1, 0);
    rd_q.push_back(push_e);
    cpu_if.addr = ad(0, 0); cpu_if.wr = 1'b0; cpu_if.en = 1'b1;
    @(negedge clk); check("contend_wt0", 16'(cpu_if.wt), 16'h0001);
    tick();
    @(negedge clk); check("contend_wt1", 16'(cpu_if.wt), 16'h0001);
    tick();
    @(negedge clk); check("contend_wt2", 16'(cpu_if.wt), 16'h0000);
    tick();
    cpu_if.en = 1'b0;
    wait_done();
    read_scroll(16'h0000, "contend_word");

    // Off-screen CPU write during a clear
    preload();
    done_q.push_back(16'd13);
    issue(1'b1, 1'b0, 16'h1234);
    repeat (3) tick();
    cpu_if.addr = 12'hFFF; cpu_if.wr = 1'b1; cpu_if.wr_data = 16'hABCD; cpu_if.en = 1'b1;
    @(negedge clk); check("offscr_wr_stall", 16'(cpu_if.wt), 16'h0000);
    tick();
    cpu_if.en = 1'b0;
    wait_done();
    cpu_read(12'hFFF, 16'hABCD, "offscr_word");
    read_all(16'h1234, "offscr_clear_word");

    // Both commands at once, then a scroll pulse while busy
    preload();
    done_q.push_back(16'd12);
    issue(1'b1, 1'b1, 16'h5555);
    repeat (2) tick();
    cmd_scroll = 1'b1;
    tick();
    cmd_scroll = 1'b0;
    wait_done();
    repeat (40) tick();
    read_all(16'h5555, "both_word");

    // Reset five cycles into a scroll, then a clean clear
    preload();
    issue(1'b0, 1'b1, 16'h0000);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'h0000);
    check("abort_dsp_en", 16'(dsp_if.en), 16'h0000);
    check("abort_done", 16'(done), 16'h0000);
    tick();
    done_q.push_back(16'd12);
    issue(1'b1, 1'b0, 16'h0720);
    wait_done();
    read_all(16'h0720, "post_rst_word");

    check("rd_q_left", 16'(rd_q.size()), 16'h0000);
    check("done_q_left", 16'(done_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
